// File: rtl/enc_pkg.sv
// Shared definitions for the Diffie-Hellman encryption datapath stages.
// Holds the job-control state type and the default operand widths that the
// exponentiation, encryption and decryption stages agree on.
package enc_pkg;

    // Default dividend/data width and modulus/key width.
    localparam int unsigned DefDw = 64;
    localparam int unsigned DefPw = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/mod_reduce_serial.sv
// Bit-serial restoring reducer: computes dividend_i mod modulus_i, one
// dividend bit per clock, MSB first. There is no combinational divider.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start_i    clears the remainder and arms the bit counter
//   dividend_i dividend, held stable by the caller while reducing
//   modulus_i  non-zero modulus, held stable by the caller while reducing
//   rem_o      running remainder; final once the job has retired
//   valid_o    high in the cycle whose rising edge retires dividend bit 0,
//              so rem_o holds the final remainder from the next cycle on
module mod_reduce_serial
    import enc_pkg::*;
#(
    parameter int unsigned DW = DefDw,
    parameter int unsigned PW = DefPw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [PW-1:0] modulus_i,
    output logic [PW-1:0] rem_o,
    output logic          valid_o
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CntFirst = CW'(DW - 1);

    // The remainder is always below the modulus, so PW bits are enough to
    // store it; only the shifted trial value needs the extra bit.
    logic [PW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic [PW:0]   shifted;

    always_comb begin
        shifted  = {rem_q, dividend_i[cnt_q]};
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start_i) begin
            rem_d    = '0;
            cnt_d    = CntFirst;
            active_d = 1'b1;
        end else if (active_q) begin
            // Compare and subtract at PW+1 bits so a shifted-out MSB is not lost.
            if (shifted >= {1'b0, modulus_i}) begin
                rem_d = PW'(shifted - {1'b0, modulus_i});
            end else begin
                rem_d = shifted[PW-1:0];
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign rem_o   = rem_q;
    assign valid_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/enc_mod_xor_seq.sv
// Multi-cycle modular-key encryption stage: key = exp mod p via a bit-serial
// reducer, then ciphertext = zero-extended key ^ data. A zero modulus is
// reported as an error without iterating.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start_i  one-cycle request, only sampled while idle
//   exp_i    dividend (exponentiation result), DW bits
//   p_i      modulus, PW bits
//   data_i   plaintext / value to mask, DW bits
//   busy_o   high while a job is running or completing
//   done_o   one-cycle pulse when results are valid
//   err_o    zero-modulus flag; held until the next accepted start
//   key_o    exp mod p; held until the next accepted start
//   c_o      zero-extended key ^ data; held until the next accepted start
module enc_mod_xor_seq
    import enc_pkg::*;
#(
    parameter int unsigned DW = DefDw,
    parameter int unsigned PW = DefPw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [DW-1:0] exp_i,
    input  logic [PW-1:0] p_i,
    input  logic [DW-1:0] data_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [PW-1:0] key_o,
    output logic [DW-1:0] c_o
);

    state_e        state_q, state_d;
    logic [DW-1:0] exp_q, data_q, c_q, c_res;
    logic [PW-1:0] p_q, key_q, key_res, red_rem;
    logic          err_q;
    logic          accept, red_start, red_last, in_done;

    mod_reduce_serial #(
        .DW (DW),
        .PW (PW)
    ) u_reduce (
        .clk        (clk),
        .rst        (rst),
        .start_i    (red_start),
        .dividend_i (exp_q),
        .modulus_i  (p_q),
        .rem_o      (red_rem),
        .valid_o    (red_last)
    );

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        red_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    accept = 1'b1;
                    if (p_i == '0) begin
                        state_d = StDone;
                    end else begin
                        red_start = 1'b1;
                        state_d   = StRun;
                    end
                end
            end
            StRun: begin
                if (red_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The reducer's remainder may be stale from an earlier job on the error
    // path, so the error flag masks it.
    always_comb begin
        key_res = err_q ? '0 : red_rem;
        c_res   = err_q ? '0 : (DW'(key_res) ^ data_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            exp_q   <= '0;
            p_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            key_q   <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                exp_q  <= exp_i;
                p_q    <= p_i;
                data_q <= data_i;
                err_q  <= (p_i == '0);
            end
            if (state_q == StDone) begin
                key_q <= key_res;
                c_q   <= c_res;
            end
        end
    end

    // Results are presented straight from the reducer during the done cycle
    // and from the holding registers afterwards.
    assign in_done = (state_q == StDone);
    assign busy_o  = (state_q != StIdle);
    assign done_o  = in_done;
    assign err_o   = err_q;
    assign key_o   = in_done ? key_res : key_q;
    assign c_o     = in_done ? c_res : c_q;

endmodule

// File: tb/tb_enc_mod_xor_seq.sv
// Self-checking bench for enc_mod_xor_seq (DW=64, PW=32): directed plan
// vectors, zero modulus, held start with back-to-back jobs, reset mid-job
// and randomized jobs against a plain arithmetic reference.
module tb_enc_mod_xor_seq;

    localparam int unsigned DW = 64;
    localparam int unsigned PW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [DW-1:0] exp_i = '0;
    logic [PW-1:0] p_i = '0;
    logic [DW-1:0] data_i = '0;
    logic          busy_o, done_o, err_o;
    logic [PW-1:0] key_o;
    logic [DW-1:0] c_o;

    int n_cmp = 0;
    int n_bad = 0;

    enc_mod_xor_seq #(
        .DW (DW),
        .PW (PW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .exp_i   (exp_i),
        .p_i     (p_i),
        .data_i  (data_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .key_o   (key_o),
        .c_o     (c_o)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] ref_key(input logic [DW-1:0] e, input logic [PW-1:0] p);
        logic [DW-1:0] r;
        if (p == '0) return '0;
        r = e % DW'(p);
        return r[PW-1:0];
    endfunction

    function automatic logic [DW-1:0] ref_c(input logic [DW-1:0] e, input logic [PW-1:0] p,
                                            input logic [DW-1:0] d);
        if (p == '0) return '0;
        return DW'(ref_key(e, p)) ^ d;
    endfunction

    function automatic logic [DW-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Issues one job from idle, scrambles the inputs after acceptance and waits
    // (bounded) for done_o. edges counts rising edges from the accepting one;
    // -1 means done_o never came. k_early/c_early are sampled one cycle after
    // acceptance.
    task automatic do_job(input logic [DW-1:0] e_in, input logic [PW-1:0] p_in,
                          input logic [DW-1:0] d_in, output logic [PW-1:0] k,
                          output logic [DW-1:0] c, output logic er, output int edges,
                          output logic [PW-1:0] k_early, output logic [DW-1:0] c_early);
        @(negedge clk);
        exp_i   = e_in;
        p_i     = p_in;
        data_i  = d_in;
        start_i = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start_i = 1'b0;
        k_early = key_o;
        c_early = c_o;
        exp_i   = rand64();
        p_i     = $urandom;
        data_i  = rand64();
        while (!done_o && edges < int'(DW) + 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!done_o) edges = -1;
        k  = key_o;
        c  = c_o;
        er = err_o;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset busy_o: got %0b want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset done_o: got %0b want 0", done_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset err_o: got %0b want 0", err_o); end
        n_cmp++; if (key_o !== '0) begin n_bad++; $display("FAIL reset key_o: got %h want 0", key_o); end
        n_cmp++; if (c_o !== '0) begin n_bad++; $display("FAIL reset c_o: got %h want 0", c_o); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL idle busy_o: got %0b want 0", busy_o); end
    endtask

    task automatic test_directed();
        logic [DW-1:0] e_tab [4];
        logic [PW-1:0] p_tab [4];
        logic [DW-1:0] d_tab [4];
        logic [PW-1:0] k_want [4];
        logic [DW-1:0] c_want [4];
        logic [PW-1:0] k, ke;
        logic [DW-1:0] c, ce;
        logic          er;
        int            edges;
        e_tab[0] = 64'd100;   p_tab[0] = 32'd23; d_tab[0] = 64'hFF;   k_want[0] = 32'd8; c_want[0] = 64'hF7;
        e_tab[1] = 64'd5;     p_tab[1] = 32'd23; d_tab[1] = 64'h0;    k_want[1] = 32'd5; c_want[1] = 64'h5;
        e_tab[2] = 64'hDEAD;  p_tab[2] = 32'd1;  d_tab[2] = 64'hA5A5_0F0F_1234_5678;
        k_want[2] = 32'd0; c_want[2] = 64'hA5A5_0F0F_1234_5678;
        e_tab[3] = 64'hFFFF_FFFF_FFFF_FFFF; p_tab[3] = 32'hFFFF_FFFF; d_tab[3] = 64'h1234;
        k_want[3] = 32'd0; c_want[3] = 64'h1234;
        for (int i = 0; i < 4; i++) begin
            do_job(e_tab[i], p_tab[i], d_tab[i], k, c, er, edges, ke, ce);
            n_cmp++; if (edges !== int'(DW) + 1) begin n_bad++; $display("FAIL dir%0d latency: got %0d edges want %0d", i, edges, DW + 1); end
            n_cmp++; if (k !== k_want[i]) begin n_bad++; $display("FAIL dir%0d key_o: got %h want %h", i, k, k_want[i]); end
            n_cmp++; if (c !== c_want[i]) begin n_bad++; $display("FAIL dir%0d c_o: got %h want %h", i, c, c_want[i]); end
            n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL dir%0d err_o: got %0b want 0", i, er); end
            @(negedge clk);
            n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL dir%0d done pulse width: done_o still %0b", i, done_o); end
            n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL dir%0d busy after done: got %0b want 0", i, busy_o); end
            n_cmp++; if (key_o !== k_want[i]) begin n_bad++; $display("FAIL dir%0d key hold: got %h want %h", i, key_o, k_want[i]); end
            n_cmp++; if (c_o !== c_want[i]) begin n_bad++; $display("FAIL dir%0d c hold: got %h want %h", i, c_o, c_want[i]); end
        end
    endtask

    task automatic test_zero_mod();
        logic [PW-1:0] k, ke;
        logic [DW-1:0] c, ce;
        logic          er;
        int            edges;
        do_job(64'd77, 32'd0, rand64(), k, c, er, edges, ke, ce);
        n_cmp++; if (edges !== 1) begin n_bad++; $display("FAIL zero latency: got %0d edges want 1", edges); end
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL zero err_o: got %0b want 1", er); end
        n_cmp++; if (k !== '0) begin n_bad++; $display("FAIL zero key_o: got %h want 0", k); end
        n_cmp++; if (c !== '0) begin n_bad++; $display("FAIL zero c_o: got %h want 0", c); end
        @(negedge clk);
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL zero err hold: got %0b want 1", err_o); end
        do_job(64'd200, 32'd9, 64'h55, k, c, er, edges, ke, ce);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL zero-then-valid err_o: got %0b want 0", er); end
        n_cmp++; if (k !== 32'd2) begin n_bad++; $display("FAIL zero-then-valid key_o: got %h want 2", k); end
        n_cmp++; if (c !== 64'h57) begin n_bad++; $display("FAIL zero-then-valid c_o: got %h want 57", c); end
    endtask

    // start_i stays high across three jobs; operands change mid-run and while
    // done_o is high, and each job must use the operands present at its own
    // accepting edge.
    task automatic test_back_to_back();
        logic [DW-1:0] e_tab [3];
        logic [PW-1:0] p_tab [3];
        logic [DW-1:0] d_tab [3];
        int            j = 0;
        int            n = 0;
        int            dones = 0;
        for (int i = 0; i < 3; i++) begin
            e_tab[i] = rand64();
            p_tab[i] = $urandom | 32'h1;
            d_tab[i] = rand64();
        end
        @(negedge clk);
        exp_i   = e_tab[0];
        p_i     = p_tab[0];
        data_i  = d_tab[0];
        start_i = 1'b1;
        while (n < 3 * (int'(DW) + 2) + 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done_o) begin
                dones++;
                if (j < 3) begin
                    n_cmp++; if (n !== 1 + int'(DW) + j * (int'(DW) + 2)) begin n_bad++; $display("FAIL b2b%0d done edge: got %0d want %0d", j, n, 1 + DW + j * (DW + 2)); end
                    n_cmp++; if (key_o !== ref_key(e_tab[j], p_tab[j])) begin n_bad++; $display("FAIL b2b%0d key_o: got %h want %h", j, key_o, ref_key(e_tab[j], p_tab[j])); end
                    n_cmp++; if (c_o !== ref_c(e_tab[j], p_tab[j], d_tab[j])) begin n_bad++; $display("FAIL b2b%0d c_o: got %h want %h", j, c_o, ref_c(e_tab[j], p_tab[j], d_tab[j])); end
                end
                j++;
                if (j < 3) begin
                    exp_i  = e_tab[j];
                    p_i    = p_tab[j];
                    data_i = d_tab[j];
                end else begin
                    start_i = 1'b0;
                end
            end else if (((n - 1) % (int'(DW) + 2)) == 20) begin
                exp_i  = rand64();
                p_i    = $urandom;
                data_i = rand64();
            end
        end
        start_i = 1'b0;
        n_cmp++; if (dones !== 3) begin n_bad++; $display("FAIL b2b done count: got %0d want 3", dones); end
    endtask

    task automatic test_reset_mid();
        logic [PW-1:0] k, ke;
        logic [DW-1:0] c, ce;
        logic          er;
        int            edges;
        int            dones = 0;
        do_job(64'd1000, 32'd7, 64'h0, k, c, er, edges, ke, ce);
        n_cmp++; if (k !== 32'd6) begin n_bad++; $display("FAIL pre-reset key_o: got %h want 6", k); end
        @(negedge clk);
        exp_i   = rand64();
        p_i     = $urandom | 32'h1;
        data_i  = rand64();
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (29) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL midrst busy_o: got %0b want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL midrst done_o: got %0b want 0", done_o); end
        n_cmp++; if (key_o !== '0) begin n_bad++; $display("FAIL midrst key_o: got %h want 0", key_o); end
        n_cmp++; if (c_o !== '0) begin n_bad++; $display("FAIL midrst c_o: got %h want 0", c_o); end
        @(negedge clk);
        rst = 1'b0;
        repeat (DW + 10) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL midrst stray done: got %0d pulses want 0", dones); end
        do_job(64'h0123_4567_89AB_CDEF, 32'hDEAD_BEEF, 64'h0F0F, k, c, er, edges, ke, ce);
        n_cmp++; if (k !== ref_key(64'h0123_4567_89AB_CDEF, 32'hDEAD_BEEF)) begin n_bad++; $display("FAIL post-reset key_o: got %h want %h", k, ref_key(64'h0123_4567_89AB_CDEF, 32'hDEAD_BEEF)); end
        n_cmp++; if (c !== ref_c(64'h0123_4567_89AB_CDEF, 32'hDEAD_BEEF, 64'h0F0F)) begin n_bad++; $display("FAIL post-reset c_o: got %h want %h", c, ref_c(64'h0123_4567_89AB_CDEF, 32'hDEAD_BEEF, 64'h0F0F)); end
        n_cmp++; if (edges !== int'(DW) + 1) begin n_bad++; $display("FAIL post-reset latency: got %0d want %0d", edges, DW + 1); end
    endtask

    task automatic test_random();
        logic [DW-1:0] e, d, c, ce, prev_c;
        logic [PW-1:0] p, k, ke, prev_k;
        logic          er;
        int            edges, sel;
        logic          have_prev = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0) p = '0;
            else if (sel == 1) p = PW'($urandom_range(1, 3));
            else if (sel == 2) p = 32'hFFFF_FFFF;
            else p = $urandom;
            e = ($urandom_range(0, 5) == 0) ? DW'($urandom_range(0, 50)) : rand64();
            d = rand64();
            do_job(e, p, d, k, c, er, edges, ke, ce);
            n_cmp++; if (k !== ref_key(e, p)) begin n_bad++; $display("FAIL rnd%0d key_o: got %h want %h", i, k, ref_key(e, p)); end
            n_cmp++; if (c !== ref_c(e, p, d)) begin n_bad++; $display("FAIL rnd%0d c_o: got %h want %h", i, c, ref_c(e, p, d)); end
            n_cmp++; if (er !== (p == '0)) begin n_bad++; $display("FAIL rnd%0d err_o: got %0b want %0b", i, er, (p == '0)); end
            n_cmp++; if (edges !== ((p == '0) ? 1 : int'(DW) + 1)) begin n_bad++; $display("FAIL rnd%0d latency: got %0d", i, edges); end
            if (have_prev && p != '0) begin
                n_cmp++; if (ke !== prev_k) begin n_bad++; $display("FAIL rnd%0d key held in run: got %h want %h", i, ke, prev_k); end
                n_cmp++; if (ce !== prev_c) begin n_bad++; $display("FAIL rnd%0d c held in run: got %h want %h", i, ce, prev_c); end
            end
            prev_k    = ref_key(e, p);
            prev_c    = ref_c(e, p, d);
            have_prev = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_mod();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/enc_mod_xor_seq.md
Name: enc_mod_xor_seq

Overview:
Parametrised, multi-cycle successor to the single-cycle modular-key encryption stage. Computes key = exp_i mod p_i with a bit-serial restoring reducer (no combinational divider), then produces ciphertext c_o = key ^ data_i. Sits after the exponentiation stage in the Diffie-Hellman datapath. Uses a start/busy/done handshake and flags a zero modulus as an error.

Parameters:
DW, 64, width of exp_i, data_i, c_o; legal range 8..128
PW, 32, width of p_i and key_o; PW <= DW

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start_i  input  1  one-cycle request; sampled only in IDLE
exp_i  input  DW  dividend (exponentiation result)
p_i  input  PW  modulus
data_i  input  DW  plaintext / random value to mask
busy_o  output  1  high while a job is in progress (RUN or DONE)
done_o  output  1  one-cycle pulse when results are valid
err_o  output  1  set with done_o if p_i == 0; held until next accepted start
key_o  output  PW  exp_i mod p_i; held until next accepted start
c_o  output  DW  {zero-extended key_o} ^ data_i; held until next accepted start

Behaviour:
- Reset (async, rst=1): state IDLE; busy_o, done_o, err_o = 0; key_o, c_o = 0; internal remainder, bit counter and operand registers cleared.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start_i=1, latch exp_i, p_i, data_i; clear remainder (PW+1 bits); set counter = DW-1; clear err_o; key_o/c_o keep old values.
  - If latched p == 0: go directly to DONE with err flagged; no iteration.
  - Otherwise go to RUN.
- RUN: one dividend bit per edge, MSB first: r' = {r[PW-1:0], exp[cnt]}; if r' >= p then r = r' - p else r = r'. Compare and subtract at PW+1 bits.
  - After processing bit 0, go to DONE. RUN lasts exactly DW edges.
- DONE (one cycle):
  - done_o = 1.
  - key_o = r[PW-1:0]; c_o = {{(DW-PW){1'b0}}, key_o} ^ data.
  - On error: err_o = 1, key_o = 0, c_o = 0.
  - Next edge returns to IDLE.
- Latency: done_o is high in the cycle following the (DW+1)th edge after the accepting edge (normal). With p == 0 it is high after the 1st edge.
- busy_o = 1 in RUN and DONE; start_i is ignored whenever busy_o = 1. Input changes after acceptance have no effect.
- start_i asserted in the same cycle done_o is high: ignored. A start is only accepted on the following IDLE cycle.
- Arithmetic boundaries:
  - p == 1 gives key 0.
  - exp < p gives key = exp.
  - Remainder is always < p, so it fits in PW bits.
- Reset mid-operation: all state discards immediately; no done_o pulse is produced for the aborted job.

Decomposition:
- Package enc_pkg holds the state typedef (IDLE/RUN/DONE) and default DW/PW constants shared with the exponentiation and decryption stages.
- Natural sub-module: mod_reduce_serial, containing the remainder register, counter and compare/subtract. Its interface is start/dividend/modulus in and rem/valid out.
- The top level holds the FSM, operand latches, XOR and output registers.

Test Plan:
- DW=64,PW=32: exp=100, p=23, data=0xFF -> done_o at edge 65 after start; key_o=8, c_o=0xF7, err_o=0.
- exp=5, p=23, data=0 -> key_o=5, c_o=5. Separately, p=1, exp=0xDEAD -> key_o=0, c_o=data_i.
- exp=0xFFFF_FFFF_FFFF_FFFF, p=0xFFFF_FFFF, data=0x1234 -> key_o=0, c_o=0x1234 (checks the PW+1-bit compare).
- p=0, exp=77 -> done_o one edge after start; err_o=1, key_o=0, c_o=0. The next valid job clears err_o.
- start_i held high through a job, with exp_i/p_i changed mid-RUN -> exactly one done_o per accepted start, computed from the latched operands. Back-to-back jobs are spaced DW+2 edges apart.
- rst pulsed at RUN cycle 30 -> outputs 0, busy_o=0, no done_o. A fresh start then completes correctly. Compare every result against a reference (exp % p) ^ data over 1000 random operands.
